// File: rtl/stf_detect_pkg.sv
// Shared widths, FSM state type and the |C| magnitude approximation for stf_detect.
// Build option: STF_DETECT_CFO_EN keeps the correlation capture registers.
// No timing of its own; the constants size the 3-stage detector pipeline.
package stf_detect_pkg;

   localparam int SAMPLE_W = 16;
   localparam int PROD_W   = 33;
   localparam int ACC_W    = 37;
   localparam int MAG_W    = 38;
   localparam int CMP_W    = 41;

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_SEARCH  = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_t;

   // One lag-product term plus the power of the newest sample.
   typedef struct packed {
      logic signed [PROD_W-1:0] re;
      logic signed [PROD_W-1:0] im;
      logic        [PROD_W-1:0] pwr;
   } prod_t;

   // |C| ~= max(|re|,|im|) + min(|re|,|im|)/2; one extra bit absorbs |-2^36|.
   function automatic logic [MAG_W-1:0] mag_approx(input logic signed [ACC_W-1:0] re,
                                                   input logic signed [ACC_W-1:0] im);
      logic signed [MAG_W-1:0] re_x;
      logic signed [MAG_W-1:0] im_x;
      logic        [MAG_W-1:0] a_re;
      logic        [MAG_W-1:0] a_im;
      logic        [MAG_W-1:0] mx;
      logic        [MAG_W-1:0] mn;
      re_x = MAG_W'(re);
      im_x = MAG_W'(im);
      a_re = re_x[MAG_W-1] ? $unsigned(-re_x) : $unsigned(re_x);
      a_im = im_x[MAG_W-1] ? $unsigned(-im_x) : $unsigned(im_x);
      mx   = (a_re > a_im) ? a_re : a_im;
      mn   = (a_re > a_im) ? a_im : a_re;
      return mx + (mn >> 1);
   endfunction

endpackage

// File: rtl/stf_corr_window.sv
// Lag-LAG delayed autocorrelation and windowed power as WIN-deep running sums.
// Latency: 2 clocks from sample_in_strobe to c_vld (products, then accumulators).
// No backpressure; every stage advances only on its valid, clear flushes all history.
module stf_corr_window
   import stf_detect_pkg::*;
#(
   parameter int WIN = 16,
   parameter int LAG = 16
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic [31:0]             sample_in,
   input  logic                    sample_in_strobe,
   output logic signed [ACC_W-1:0] c_re,
   output logic signed [ACC_W-1:0] c_im,
   output logic [ACC_W-1:0]        p_pow,
   output logic                    c_vld
);

   logic [31:0]             dly_q [LAG];
   logic [31:0]             dly_d [LAG];
   prod_t                   prod_q, prod_d;
   logic                    vld1_q, vld1_d;
   prod_t                   fifo_q [WIN];
   prod_t                   fifo_d [WIN];
   logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
   logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
   logic [ACC_W-1:0]        acc_pw_q, acc_pw_d;
   logic                    vld2_q, vld2_d;

   logic signed [PROD_W-1:0] i_x, q_x, id_x, qd_x;

   // s(n) against s(n-LAG), the oldest entry of the delay line; full precision in 33 bits
   always_comb begin
      i_x  = PROD_W'($signed(sample_in[31:16]));
      q_x  = PROD_W'($signed(sample_in[15:0]));
      id_x = PROD_W'($signed(dly_q[LAG-1][31:16]));
      qd_x = PROD_W'($signed(dly_q[LAG-1][15:0]));
   end

   // stage 1: shift the delay line and form the product and power terms
   always_comb begin
      dly_d  = dly_q;
      prod_d = prod_q;
      vld1_d = 1'b0;
      if (clear) begin
         dly_d  = '{default: '0};
         prod_d = '0;
      end else if (sample_in_strobe) begin
         dly_d[0] = sample_in;
         for (int i = 1; i < LAG; i++) begin
            dly_d[i] = dly_q[i-1];
         end
         prod_d.re  = i_x * id_x + q_x * qd_x;
         prod_d.im  = q_x * id_x - i_x * qd_x;
         prod_d.pwr = $unsigned(i_x * i_x + q_x * q_x);
         vld1_d     = 1'b1;
      end
   end

   // stage 2: add the newest term, drop the one WIN samples old
   always_comb begin
      fifo_d   = fifo_q;
      acc_re_d = acc_re_q;
      acc_im_d = acc_im_q;
      acc_pw_d = acc_pw_q;
      vld2_d   = 1'b0;
      if (clear) begin
         fifo_d   = '{default: '0};
         acc_re_d = '0;
         acc_im_d = '0;
         acc_pw_d = '0;
      end else if (vld1_q) begin
         fifo_d[0] = prod_q;
         for (int i = 1; i < WIN; i++) begin
            fifo_d[i] = fifo_q[i-1];
         end
         acc_re_d = acc_re_q + ACC_W'($signed(prod_q.re)) - ACC_W'($signed(fifo_q[WIN-1].re));
         acc_im_d = acc_im_q + ACC_W'($signed(prod_q.im)) - ACC_W'($signed(fifo_q[WIN-1].im));
         acc_pw_d = acc_pw_q + ACC_W'(prod_q.pwr) - ACC_W'(fifo_q[WIN-1].pwr);
         vld2_d   = 1'b1;
      end
   end

   // pipeline registers for both stages
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         dly_q    <= '{default: '0};
         prod_q   <= '0;
         vld1_q   <= 1'b0;
         fifo_q   <= '{default: '0};
         acc_re_q <= '0;
         acc_im_q <= '0;
         acc_pw_q <= '0;
         vld2_q   <= 1'b0;
      end else begin
         dly_q    <= dly_d;
         prod_q   <= prod_d;
         vld1_q   <= vld1_d;
         fifo_q   <= fifo_d;
         acc_re_q <= acc_re_d;
         acc_im_q <= acc_im_d;
         acc_pw_q <= acc_pw_d;
         vld2_q   <= vld2_d;
      end
   end

   assign c_re  = acc_re_q;
   assign c_im  = acc_im_q;
   assign p_pow = acc_pw_q;
   assign c_vld = vld2_q;

endmodule

// File: rtl/stf_detect.sv
// STF detector: normalised lag autocorrelation plateau -> one-cycle stf_detected pulse.
// Latency: pulse 3 clocks after the strobe of the sample completing the plateau.
// No backpressure, one sample per clock; STF_DETECT_CFO_EN keeps the corr_* capture.
module stf_detect
   import stf_detect_pkg::*;
#(
   parameter int unsigned WIN         = 16,
   parameter int unsigned LAG         = 16,
   parameter int unsigned THRESH      = 6,
   parameter logic [31:0] MIN_POWER   = 32'd4096,
   parameter int unsigned MIN_PLATEAU = 48,
   parameter int unsigned HOLDOFF     = 160
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic [31:0]             sample_in,
   input  logic                    sample_in_strobe,
   output logic                    stf_detected,
   output logic signed [ACC_W-1:0] corr_re,
   output logic signed [ACC_W-1:0] corr_im,
   output logic [1:0]              state_dbg
);

   localparam int WARM_W = $clog2(LAG + WIN + 1);
   localparam int PLAT_W = $clog2(MIN_PLATEAU + 1);
   localparam int HOLD_W = $clog2(HOLDOFF + 1);

   logic signed [ACC_W-1:0] c_re, c_im;
   logic [ACC_W-1:0]        p_pow;
   logic                    c_vld;

   stf_corr_window #(.WIN(WIN), .LAG(LAG)) u_win (
      .clock            (clock),
      .rstn             (rstn),
      .clear            (clear),
      .sample_in        (sample_in),
      .sample_in_strobe (sample_in_strobe),
      .c_re             (c_re),
      .c_im             (c_im),
      .p_pow            (p_pow),
      .c_vld            (c_vld)
   );

   logic [MAG_W-1:0] mag;
   logic [CMP_W-1:0] mag_x8, pow_th;
   logic             hit;

   // ratio test |C|/P > THRESH/8 without a divider, plus the absolute power floor
   always_comb begin
      mag    = mag_approx(c_re, c_im);
      mag_x8 = {mag, 3'b000};
      pow_th = CMP_W'(p_pow) * CMP_W'(THRESH);
      hit    = (mag_x8 > pow_th) && (p_pow > ACC_W'(MIN_POWER));
   end

   state_t              state_q, state_d;
   logic [WARM_W-1:0]   warm_q, warm_d;
   logic [PLAT_W-1:0]   plat_q, plat_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                det_q, det_d;

   // stage 3 FSM: the first LAG+WIN-1 samples have incomplete windows and are skipped
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      plat_d  = plat_q;
      hold_d  = hold_q;
      det_d   = 1'b0;
      if (clear) begin
         state_d = ST_WARMUP;
         warm_d  = '0;
         plat_d  = '0;
         hold_d  = '0;
      end else if (c_vld) begin
         case (state_q)
            ST_WARMUP: begin
               if (warm_q == WARM_W'(LAG + WIN - 2)) begin
                  state_d = ST_SEARCH;
                  warm_d  = '0;
               end else begin
                  warm_d = warm_q + WARM_W'(1);
               end
            end
            ST_SEARCH: begin
               if (!hit) begin
                  plat_d = '0;
               end else if (plat_q == PLAT_W'(MIN_PLATEAU - 1)) begin
                  det_d   = 1'b1;
                  state_d = ST_HOLDOFF;
                  plat_d  = '0;
                  hold_d  = '0;
               end else begin
                  plat_d = plat_q + PLAT_W'(1);
               end
            end
            ST_HOLDOFF: begin
               if (hold_q == HOLD_W'(HOLDOFF - 1)) begin
                  state_d = ST_SEARCH;
                  hold_d  = '0;
                  plat_d  = '0;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            default: begin
               state_d = ST_WARMUP;
               warm_d  = '0;
            end
         endcase
      end
   end

   // FSM, counters and the registered detection pulse
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_WARMUP;
         warm_q  <= '0;
         plat_q  <= '0;
         hold_q  <= '0;
         det_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         plat_q  <= plat_d;
         hold_q  <= hold_d;
         det_q   <= det_d;
      end
   end

   assign stf_detected = det_q;
   assign state_dbg    = state_q;

`ifdef STF_DETECT_CFO_EN
   logic signed [ACC_W-1:0] corr_re_q, corr_re_d;
   logic signed [ACC_W-1:0] corr_im_q, corr_im_d;

   // capture C with the detecting sample; clear leaves the last estimate in place
   always_comb begin
      corr_re_d = corr_re_q;
      corr_im_d = corr_im_q;
      if (det_d) begin
         corr_re_d = c_re;
         corr_im_d = c_im;
      end
   end

   // correlation capture registers
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         corr_re_q <= '0;
         corr_im_q <= '0;
      end else begin
         corr_re_q <= corr_re_d;
         corr_im_q <= corr_im_d;
      end
   end

   assign corr_re = corr_re_q;
   assign corr_im = corr_im_q;
`else
   assign corr_re = '0;
   assign corr_im = '0;
`endif

endmodule

// File: tb/tb_stf_detect.sv
// Directed bench for stf_detect with a window-sum reference model and per-cycle compare.
// Expected pulse lands 3 clocks after the completing strobe; clear/reset flush the model.
// Build option STF_DETECT_CFO_EN selects whether corr_* expectations are live or zero.
module tb_stf_detect;

   localparam int  MAXC = 4096;
   localparam int  WIN = 16, LAG = 16, THRESH = 6, MIN_PLAT = 48, HOLD = 160;
   localparam longint MIN_POW = 4096;
`ifdef STF_DETECT_CFO_EN
   localparam longint CFO = 1;
`else
   localparam longint CFO = 0;
`endif

   logic               clock = 1'b0;
   logic               rstn, clear, sample_in_strobe;
   logic [31:0]        sample_in;
   logic               stf_detected;
   logic signed [36:0] corr_re, corr_im;
   logic [1:0]         state_dbg;

   stf_detect dut (
      .clock            (clock),
      .rstn             (rstn),
      .clear            (clear),
      .sample_in        (sample_in),
      .sample_in_strobe (sample_in_strobe),
      .stf_detected     (stf_detected),
      .corr_re          (corr_re),
      .corr_im          (corr_im),
      .state_dbg        (state_dbg)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0, failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // expectations scheduled per cycle
   bit     exp_det [MAXC];
   bit     exp_stf [MAXC];
   int     exp_stv [MAXC];
   longint exp_cre [MAXC];
   longint exp_cim [MAXC];

   // reference model: session history since last clear/reset
   longint si [1024];
   longint sq [1024];
   int     ns, m_st, m_w, m_pc, m_h;

   function automatic void flush_from(int c);
      for (int k = c; k < MAXC; k++) begin
         exp_det[k] = 1'b0;
         exp_stf[k] = 1'b0;
      end
   endfunction

   function automatic void model_session();
      ns = 0; m_st = 0; m_w = 0; m_pc = 0; m_h = 0;
   endfunction

   function automatic void model_sample(input logic [31:0] s, input int c);
      longint cre = 0, cim = 0, pw = 0, ar, ai, mag;
      bit hit, det = 1'b0;
      int n = ns;
      si[n] = longint'($signed(s[31:16]));
      sq[n] = longint'($signed(s[15:0]));
      ns++;
      // direct window sums over history; samples before the session are zero
      for (int k = n - WIN + 1; k <= n; k++) begin
         if (k >= 0) begin
            pw += si[k] * si[k] + sq[k] * sq[k];
            if (k >= LAG) begin
               cre += si[k] * si[k-LAG] + sq[k] * sq[k-LAG];
               cim += sq[k] * si[k-LAG] - si[k] * sq[k-LAG];
            end
         end
      end
      ar  = (cre < 0) ? -cre : cre;
      ai  = (cim < 0) ? -cim : cim;
      mag = (ar > ai) ? ar + ai / 2 : ai + ar / 2;
      hit = (mag * 8 > pw * THRESH) && (pw > MIN_POW);
      if (m_st == 0) begin
         m_w++;
         if (m_w == LAG + WIN - 1) m_st = 1;
      end else if (m_st == 1) begin
         m_pc = hit ? m_pc + 1 : 0;
         if (m_pc == MIN_PLAT) begin
            det = 1'b1; m_st = 2; m_h = 0; m_pc = 0;
         end
      end else begin
         m_h++;
         if (m_h == HOLD) begin
            m_st = 1; m_pc = 0;
         end
      end
      if (c + 3 < MAXC) begin
         exp_stf[c+3] = 1'b1;
         exp_stv[c+3] = m_st;
         exp_det[c+3] = det;
         exp_cre[c+3] = CFO * cre;
         exp_cim[c+3] = CFO * cim;
      end
   endfunction

   // inputs for one cycle, applied just after the rising edge
   task automatic drive(input logic [31:0] s, input logic stb, input logic clr);
      @(posedge clock); #1;
      sample_in = s; sample_in_strobe = stb; clear = clr;
      if (clr) begin
         flush_from(cyc + 1);
         if (cyc + 1 < MAXC) begin
            exp_stf[cyc+1] = 1'b1;
            exp_stv[cyc+1] = 0;
         end
         model_session();
      end else if (stb) begin
         model_sample(s, cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(32'hDEAD_BEEF, 1'b0, 1'b0);
   endtask

   // period-16 test stream; exactly halved amplitudes when sh=1
   function automatic logic [31:0] stf_word(input int k, input int sh);
      int i, q;
      i = (((k % 16) + 1) * 100) >>> sh;
      q = ((16 - (k % 16)) * 50) >>> sh;
      return {i[15:0], q[15:0]};
   endfunction

   task automatic run_stf(input int sh, input int period, input int nsamp, output int t0);
      t0 = 0;
      for (int k = 0; k < nsamp; k++) begin
         drive(stf_word(k, sh), 1'b1, 1'b0);
         if (k == 0) t0 = cyc;
         if (period > 1) idle(period - 1);
      end
   endtask

   // per-cycle compare against the scheduled expectations
   longint cur_st = 0, cur_cre = 0, cur_cim = 0;
   int     det_seen = 0;
   int     det_cyc [$];
   always @(negedge clock) begin
      bit exp_d;
      exp_d = 1'b0;
      if (!rstn) begin
         cur_st = 0; cur_cre = 0; cur_cim = 0;
      end else if (cyc < MAXC) begin
         if (exp_stf[cyc]) cur_st = exp_stv[cyc];
         if (exp_det[cyc]) begin
            cur_cre = exp_cre[cyc];
            cur_cim = exp_cim[cyc];
         end
         exp_d = exp_det[cyc];
      end
      check("stf_detected", longint'(stf_detected), longint'(exp_d));
      check("state_dbg", longint'(state_dbg), cur_st);
      check("corr_re", longint'(corr_re), cur_cre);
      check("corr_im", longint'(corr_im), cur_cim);
      if (stf_detected) begin
         det_seen++;
         det_cyc.push_back(cyc);
      end
   end

   function automatic int det_at(input int idx);
      return (det_cyc.size() > idx) ? det_cyc[idx] : -1;
   endfunction

   initial begin
      int t0, d0, c;
      rstn = 1'b0; clear = 1'b0; sample_in_strobe = 1'b0; sample_in = '0;
      model_session();
      #2;
      check("reset_det", longint'(stf_detected), 0);
      check("reset_state", longint'(state_dbg), 0);
      check("reset_corr_re", longint'(corr_re), 0);
      check("reset_corr_im", longint'(corr_im), 0);
      repeat (3) @(posedge clock);
      #1 rstn = 1'b1;

      // full-scale stream: plateau 31..78, pulse 3 clocks after index 78
      d0 = det_seen;
      run_stf(0, 1, 160, t0);
      idle(6);
      check("t1_pulse_count", det_seen - d0, 1);
      check("t1_pulse_cycle", det_at(d0), t0 + 81);
      check("t1_corr_re", longint'(corr_re), CFO * 18700000);
      check("t1_corr_im", longint'(corr_im), 0);
      drive(32'h0, 1'b0, 1'b1);
      idle(2);

      // half scale: same cycle, quarter correlation
      d0 = det_seen;
      run_stf(1, 1, 160, t0);
      idle(6);
      check("t2_pulse_count", det_seen - d0, 1);
      check("t2_pulse_cycle", det_at(d0), t0 + 81);
      check("t2_corr_re", longint'(corr_re), CFO * 4675000);
      drive(32'h0, 1'b0, 1'b1);
      idle(2);

      // zeros then white noise: nothing to detect
      d0 = det_seen;
      for (int k = 0; k < 400; k++) drive(32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 400; k++) begin
         int i, q;
         i = int'($urandom_range(16000)) - 8000;
         q = int'($urandom_range(16000)) - 8000;
         drive({i[15:0], q[15:0]}, 1'b1, 1'b0);
      end
      idle(6);
      check("t3_pulse_count", det_seen - d0, 0);
      drive(32'h0, 1'b0, 1'b1);
      idle(2);

      // two STFs 200 zeros apart: two pulses, second well past holdoff
      d0 = det_seen;
      run_stf(0, 1, 160, t0);
      for (int k = 0; k < 200; k++) drive(32'h0, 1'b1, 1'b0);
      for (int k = 0; k < 160; k++) drive(stf_word(k, 0), 1'b1, 1'b0);
      idle(6);
      check("t4_pulse_count", det_seen - d0, 2);
      check("t4_first_cycle", det_at(d0), t0 + 81);
      check("t4_gap_gt_holdoff", longint'((det_at(d0 + 1) - det_at(d0)) > HOLD), 1);
      drive(32'h0, 1'b0, 1'b1);
      idle(2);

      // clear at index 60 drops that sample and restarts warmup
      d0 = det_seen;
      for (int k = 0; k < 60; k++) drive(stf_word(k, 0), 1'b1, 1'b0);
      drive(stf_word(60, 0), 1'b1, 1'b1);
      check("t5_state_before_clear", longint'(state_dbg), 1);
      idle(1);
      check("t5_state_after_clear", longint'(state_dbg), 0);
      for (int k = 0; k < 40; k++) drive(32'h0, 1'b1, 1'b0);
      idle(6);
      check("t5_pulse_count", det_seen - d0, 0);
      drive(32'h0, 1'b0, 1'b1);
      idle(2);

      // strobe every third cycle, then asynchronous reset mid-holdoff
      d0 = det_seen;
      run_stf(0, 3, 160, t0);
      idle(6);
      check("t6_pulse_count", det_seen - d0, 1);
      check("t6_pulse_cycle", det_at(d0), t0 + 3 * 78 + 3);
      check("t6_state_holdoff", longint'(state_dbg), 2);
      @(posedge clock); #1;
      rstn = 1'b0; sample_in_strobe = 1'b0; clear = 1'b0;
      flush_from(cyc);
      model_session();
      #1;
      check("t6_rst_state", longint'(state_dbg), 0);
      check("t6_rst_det", longint'(stf_detected), 0);
      check("t6_rst_corr_re", longint'(corr_re), 0);
      check("t6_rst_corr_im", longint'(corr_im), 0);
      repeat (2) @(posedge clock);
      #1 rstn = 1'b1;
      c = cyc;
      idle(3);
      check("t6_post_reset_state", longint'(state_dbg), 0);
      check("t6_post_reset_cycles", longint'(cyc - c), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
